pwm_multichannel: RTL

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_deadtime.sv | 48 ++++
 rtl/pwm_multichannel.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multichannel PWM: per-channel control word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

  // ctrl_in bit positions: {alignment, polarity, enable}
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_POL_BIT   = 1;
  localparam int CTRL_ALIGN_BIT = 2;
  localparam int CTRL_W         = 3;

  typedef enum logic {
    ALIGN_LEFT   = 1'b0,
    ALIGN_CENTER = 1'b1
  } pwm_align_e;

  typedef struct packed {
    pwm_align_e alignment;
    logic       polarity;
    logic       enable;
  } pwm_ctrl_t;

endpackage

// File: rtl/pwm_deadtime.sv
// One-channel dead-time inserter: drives a complementary pair from a level, delaying every rising edge.
// Latency: one register stage from lvl (same as the plain output path); rising edges add dead_time clocks.
// Backpressure: none; a level change shorter than dead_time never reaches either output.
//
// Ports: clk, n_rst (async active-low); en (channel active, else both outputs 0);
//        lvl (desired primary level); dead_time (gap in clocks); out_p / out_n (complementary pair).
module pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            en,
  input  logic            lvl,
  input  logic [DT_W-1:0] dead_time,
  output logic            out_p,
  output logic            out_n
);

  logic            lvl_q;
  logic [DT_W-1:0] gap;
  logic [DT_W-1:0] gap_nxt;

  // Any level change (or being disabled) restarts the gap; both sides stay low until it drains,
  // so a pulse that flips back before the gap expires is swallowed.
  always_comb begin
    gap_nxt = gap;
    if (!en || (lvl != lvl_q)) begin
      gap_nxt = dead_time;
    end else if (gap != '0) begin
      gap_nxt = gap - DT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lvl_q <= 1'b0;
      gap   <= '0;
      out_p <= 1'b0;
      out_n <= 1'b0;
    end else begin
      lvl_q <= lvl;
      gap   <= gap_nxt;
      out_p <= en &&  lvl && (gap_nxt == '0);
      out_n <= en && !lvl && (gap_nxt == '0);
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: one shared period counter, per-channel duty/ctrl, double-buffered period and duty.
// Latency: outputs are registered, one clock after the counter value; ctrl writes act on the next edge.
// Backpressure: none; every write is accepted, period/duty are staged and commit at the period wrap.
//
// Ports: clk, n_rst (async active-low); global_en (counter run); period_in/period_wen;
//        ch_sel + duty_in/duty_wen + ctrl_in/ctrl_wen (one channel per cycle, out-of-range ignored);
//        dead_time; pwm_out/pwm_out_n per channel; period_start (wrap pulse); update_pending.
// Build option: define PWM_DEADTIME_EN to insert a pwm_deadtime stage per channel.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  parameter  int DT_W   = 8,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              global_en,
  input  logic [CNT_W-1:0]  period_in,
  input  logic              period_wen,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [CNT_W-1:0]  duty_in,
  input  logic              duty_wen,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              ctrl_wen,
  input  logic [DT_W-1:0]   dead_time,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_out_n,
  output logic              period_start,
  output logic              update_pending
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  per_act;
  logic [CNT_W-1:0]  per_stg;
  logic              per_pend;
  logic              p_zero;
  logic              wrap;
  logic              commit;
  logic [NUM_CH-1:0] duty_pend;

  assign p_zero = (per_act == '0);
  assign wrap   = !p_zero && global_en && (cnt == per_act - CNT_W'(1));
  // With no active period there is nothing to protect, so staged values land right away.
  assign commit = wrap || p_zero;

  assign update_pending = per_pend || (|duty_pend);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt          <= '0;
      per_act      <= '0;
      per_stg      <= '0;
      per_pend     <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (p_zero) begin
        cnt <= '0;
      end else if (global_en) begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
      if (commit && per_pend) begin
        per_act <= per_stg;
      end
      // A write landing on the commit edge stays pending for the next wrap.
      if (period_wen) begin
        per_stg  <= period_in;
        per_pend <= 1'b1;
      end else if (commit) begin
        per_pend <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             hit;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] duty_stg;
    logic             pend;
    pwm_ctrl_t        ctrl_q;
    pwm_ctrl_t        ctrl_nxt;
    logic [CNT_W:0]   p_x;
    logic [CNT_W:0]   c_x;
    logic [CNT_W:0]   d_min;
    logic [CNT_W:0]   lead;
    logic             raw;
    logic             on;
    logic             lvl;

    // i is always in range, so an out-of-range ch_sel never matches any channel.
    assign hit = ({1'b0, ch_sel} == (SEL_W + 1)'(i));
    assign duty_pend[i] = pend;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        duty_act <= '0;
        duty_stg <= '0;
        pend     <= 1'b0;
        ctrl_q   <= '0;
      end else begin
        ctrl_q <= ctrl_nxt;
        if (commit && pend) begin
          duty_act <= duty_stg;
        end
        if (duty_wen && hit) begin
          duty_stg <= duty_in;
          pend     <= 1'b1;
        end else if (commit) begin
          pend <= 1'b0;
        end
      end
    end

    // Output registers see the incoming ctrl word so a write is visible one edge later.
    always_comb begin
      ctrl_nxt = ctrl_q;
      if (ctrl_wen && hit) begin
        ctrl_nxt.enable    = ctrl_in[CTRL_EN_BIT];
        ctrl_nxt.polarity  = ctrl_in[CTRL_POL_BIT];
        ctrl_nxt.alignment = pwm_align_e'(ctrl_in[CTRL_ALIGN_BIT]);
      end
    end

    // Center alignment is done one bit wider so P - min(D,P) and L + min(D,P) cannot wrap.
    always_comb begin
      p_x   = {1'b0, per_act};
      c_x   = {1'b0, cnt};
      d_min = ({1'b0, duty_act} >= p_x) ? p_x : {1'b0, duty_act};
      lead  = (p_x - d_min) >> 1;
      if (ctrl_nxt.alignment == ALIGN_CENTER) begin
        raw = (c_x >= lead) && (c_x < lead + d_min);
      end else begin
        raw = (cnt < duty_act);
      end
    end

    assign on  = ctrl_nxt.enable && !p_zero;
    assign lvl = raw ^ ctrl_nxt.polarity;

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
      .DT_W (DT_W)
    ) u_deadtime (
      .clk       (clk),
      .n_rst     (n_rst),
      .en        (on),
      .lvl       (lvl),
      .dead_time (dead_time),
      .out_p     (pwm_out[i]),
      .out_n     (pwm_out_n[i])
    );
`else
    logic pwm_q;
    logic pwm_n_q;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        pwm_q   <= 1'b0;
        pwm_n_q <= 1'b0;
      end else begin
        pwm_q   <= on &&  lvl;
        pwm_n_q <= on && !lvl;
      end
    end

    assign pwm_out[i]   = pwm_q;
    assign pwm_out_n[i] = pwm_n_q;
`endif
  end

`ifdef PWM_DEADTIME_EN
`else
  // dead_time only matters when the dead-time stage is built.
  logic unused_dead_time;
  assign unused_dead_time = ^dead_time;
`endif

endmodule
